// File: rtl/uart_dbg_rx.sv
// 8N1 UART receiver feeding a FWFT byte queue; byte lands in the queue on the stop-sample cycle, visible next cycle.
// No back-pressure on rx: a byte arriving while full (and not popped) is dropped and flagged via sticky overflow.
module uart_dbg_rx #(
  parameter int SYS_CLK_FREQ   = 48_000_000,
  parameter int BAUD_RATE      = 9_600,
  parameter int MSG_QUEUE_SIZE = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  input  logic       rd,
  input  logic       clr_err,
  output logic [7:0] msg,
  output logic       empty,
  output logic       full,
  output logic       overflow,
  output logic       frame_err
);
  localparam int CLKS_PER_BIT = SYS_CLK_FREQ / BAUD_RATE;
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int AW = $clog2(MSG_QUEUE_SIZE);
  localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_LOAD = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

  state_t        state;
  logic          rx_meta;
  logic          rx_s;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift_reg;
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic [7:0]    mem [MSG_QUEUE_SIZE];

  logic cnt_done;
  logic push_vld;
  logic pop;
  logic accept;

  assign cnt_done = (baud_cnt == '0);
  assign push_vld = (state == STOP) && cnt_done && rx_s;
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop      = rd && !empty;
  // A pop in the same cycle frees the slot the incoming byte needs.
  assign accept   = push_vld && (!full || pop);
  assign msg      = empty ? 8'h00 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta   <= 1'b1;
      rx_s      <= 1'b1;
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
      frame_err <= 1'b0;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      case (state)
        IDLE: begin
          if (!rx_s) begin
            baud_cnt <= HALF_LOAD;
            state    <= START;
          end
        end
        START: begin
          if (cnt_done) begin
            if (rx_s) begin
              state <= IDLE;
            end else begin
              baud_cnt <= FULL_LOAD;
              bit_idx  <= '0;
              state    <= DATA;
            end
          end else begin
            baud_cnt <= baud_cnt - CW'(1);
          end
        end
        DATA: begin
          if (cnt_done) begin
            shift_reg <= {rx_s, shift_reg[7:1]};
            baud_cnt  <= FULL_LOAD;
            bit_idx   <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) state <= STOP;
          end else begin
            baud_cnt <= baud_cnt - CW'(1);
          end
        end
        STOP: begin
          if (cnt_done) begin
            state <= rx_s ? IDLE : BREAK;
          end else begin
            baud_cnt <= baud_cnt - CW'(1);
          end
        end
        BREAK: begin
          // Held-low line must return high before another start bit is considered.
          if (rx_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if ((state == STOP) && cnt_done && !rx_s) frame_err <= 1'b1;
      else if (clr_err)                         frame_err <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)    rd_ptr <= rd_ptr + (AW+1)'(1);
      if (push_vld && full && !pop) overflow <= 1'b1;
      else if (clr_err)             overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && accept) mem[wr_ptr[AW-1:0]] <= shift_reg;
  end

endmodule

// File: tb/tb_uart_dbg_rx.sv
// Randomised and directed bench for uart_dbg_rx; a frame-level queue model predicts every output each cycle.
module tb_uart_dbg_rx;
  localparam int CPB      = 16;
  localparam int DEPTH    = 4;
  // Edge of the stop sample relative to the edge after which the start bit is driven: 2 sync + 1 detect + half bit + 9 bits.
  localparam int STOP_OFS = 3 + CPB / 2 + 9 * CPB;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx = 1'b1;
  logic       rd = 1'b0;
  logic       clr_err = 1'b0;
  logic [7:0] msg;
  logic       empty, full, overflow, frame_err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit started = 0;

  byte unsigned mq[$];
  bit           m_ovf, m_ferr;
  int           ev_cyc[$];
  byte unsigned ev_dat[$];
  bit           ev_ok[$];
  bit           m_pop, m_push, m_ok, m_full;
  byte unsigned m_d;
  int           fall_cyc = -1;
  logic         prev_empty = 1'b1;
  bit           rdone = 0;

  uart_dbg_rx #(
    .SYS_CLK_FREQ(16),
    .BAUD_RATE(1),
    .MSG_QUEUE_SIZE(DEPTH)
  ) dut (
    .clk(clk),
    .reset(reset),
    .rx(rx),
    .rd(rd),
    .clr_err(clr_err),
    .msg(msg),
    .empty(empty),
    .full(full),
    .overflow(overflow),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Reference model: a byte queue plus pending frame outcomes keyed by the edge they land on.
  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      mq.delete();
      ev_cyc.delete();
      ev_dat.delete();
      ev_ok.delete();
      m_ovf   = 0;
      m_ferr  = 0;
      started = 1;
    end else begin
      m_pop  = rd && (mq.size() > 0);
      m_full = (mq.size() == DEPTH);
      m_push = 0;
      if (clr_err) begin
        m_ovf  = 0;
        m_ferr = 0;
      end
      if (ev_cyc.size() > 0 && ev_cyc[0] == cyc) begin
        void'(ev_cyc.pop_front());
        m_d  = ev_dat.pop_front();
        m_ok = ev_ok.pop_front();
        if (!m_ok)                m_ferr = 1;
        else if (m_full && !m_pop) m_ovf = 1;
        else                      m_push = 1;
      end
      if (m_pop)  void'(mq.pop_front());
      if (m_push) mq.push_back(m_d);
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("empty", empty, mq.size() == 0);
      chk("full", full, mq.size() == DEPTH);
      if (mq.size() > 0) chk("msg", msg, mq[0]);
      else               chk("msg", msg, 8'h00);
      chk("overflow", overflow, m_ovf);
      chk("frame_err", frame_err, m_ferr);
      if (prev_empty && !empty) fall_cyc = cyc;
      prev_empty = empty;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_rd();
    rd = 1'b1;
    tick(1);
    rd = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    tick(1);
    clr_err = 1'b0;
  endtask

  task automatic send_byte(input byte unsigned d, input bit stop_ok, input bit rd_at_stop, input int hold_low);
    ev_cyc.push_back(cyc + STOP_OFS);
    ev_dat.push_back(d);
    ev_ok.push_back(stop_ok);
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      tick(CPB);
    end
    rx = stop_ok;
    if (rd_at_stop) begin
      tick(10);
      rd = 1'b1;
      tick(1);
      rd = 1'b0;
      tick(CPB - 11);
    end else begin
      tick(CPB);
    end
    if (!stop_ok && hold_low > 0) begin
      rx = 1'b0;
      tick(hold_low);
    end
    rx = 1'b1;
    tick(6);
  endtask

  task automatic drain();
    for (int i = 0; i < 2 * DEPTH; i++) begin
      if (!empty) do_rd();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int k0;
    byte unsigned rd_byte;
    tick(2);
    reset = 1'b0;
    chk("reset_empty", empty, 1'b1);
    chk("reset_full", full, 1'b0);
    chk("reset_msg", msg, 8'h00);
    chk("reset_flags", {overflow, frame_err}, 2'b00);

    // Single byte, with exact latency from start edge to empty falling
    k0 = cyc;
    send_byte(8'hA5, 1, 0, 0);
    chk("single_msg", msg, 8'hA5);
    chk("single_latency", fall_cyc, k0 + 155);
    do_rd();
    chk("single_rd_empty", empty, 1'b1);
    chk("single_rd_msg", msg, 8'h00);

    // Glitch rejection
    rx = 1'b0;
    tick(4);
    rx = 1'b1;
    tick(20);
    chk("glitch_empty", empty, 1'b1);
    chk("glitch_ferr", frame_err, 1'b0);

    // Framing error followed by a held-low break
    send_byte(8'h3C, 0, 0, 40);
    chk("ferr_set", frame_err, 1'b1);
    chk("ferr_nopush", empty, 1'b1);
    send_byte(8'h42, 1, 0, 0);
    chk("after_break_msg", msg, 8'h42);
    pulse_clr();
    chk("ferr_clear", frame_err, 1'b0);
    drain();

    // Overflow and pointer wrap
    for (int i = 1; i <= 5; i++) begin
      send_byte(byte'(i), 1, 0, 0);
      if (i == 4) chk("ovf_full", full, 1'b1);
    end
    chk("ovf_set", overflow, 1'b1);
    for (int i = 1; i <= 4; i++) begin
      chk("ovf_readout", msg, i);
      do_rd();
    end
    chk("ovf_drained", empty, 1'b1);
    send_byte(8'h06, 1, 0, 0);
    send_byte(8'h07, 1, 0, 0);
    chk("wrap_msg6", msg, 8'h06);
    do_rd();
    chk("wrap_msg7", msg, 8'h07);
    do_rd();
    pulse_clr();
    chk("ovf_clear", overflow, 1'b0);

    // Simultaneous pop and push while full
    for (int i = 0; i < 4; i++) send_byte(byte'(8'h10 + i), 1, 0, 0);
    send_byte(8'h14, 1, 1, 0);
    chk("pp_no_ovf", overflow, 1'b0);
    chk("pp_full", full, 1'b1);
    for (int i = 0; i < 4; i++) begin
      rd_byte = byte'(8'h11 + i);
      chk("pp_readout", msg, rd_byte);
      do_rd();
    end

    // Reset during data bit 3 aborts the frame and clears the queue
    send_byte(8'h55, 1, 0, 0);
    rd_byte = 8'h3C;
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 3; i++) begin
      rx = rd_byte[i];
      tick(CPB);
    end
    rx = rd_byte[3];
    tick(8);
    reset = 1'b1;
    rx = 1'b1;
    tick(1);
    reset = 1'b0;
    chk("rst_empty", empty, 1'b1);
    chk("rst_msg", msg, 8'h00);
    chk("rst_flags", {full, overflow, frame_err}, 3'b000);
    tick(6);
    send_byte(8'h81, 1, 0, 0);
    chk("rst_next_msg", msg, 8'h81);
    do_rd();
    chk("rst_only_byte", empty, 1'b1);

    // Random traffic with background reads and error clears
    fork
      begin
        for (int n = 0; n < 40; n++) begin
          bit ok;
          ok = ($urandom_range(0, 7) != 0);
          send_byte(byte'($urandom_range(0, 255)), ok, 0, ok ? 0 : int'($urandom_range(1, 20)));
        end
        rdone = 1;
      end
      begin
        while (!rdone) begin
          rd      = ($urandom_range(0, 3) == 0);
          clr_err = ($urandom_range(0, 29) == 0);
          tick(1);
        end
        rd      = 1'b0;
        clr_err = 1'b0;
      end
    join
    drain();
    tick(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_dbg_rx.md
# uart_dbg_rx

Receive-side counterpart of the UART debug transmitter path. It deserialises 8N1 UART frames from a host on `rx` and buffers each received byte in an internal message queue. Local logic drains the queue with a read strobe. The block sits between the board's UART RX pin and any on-chip command or debug consumer, and reports framing errors and queue overflow through sticky flags.

## Interface
- `SYS_CLK_FREQ`, default 48_000_000: system clock frequency in Hz.
- `BAUD_RATE`, default 9_600: line rate in bit/s. `CLKS_PER_BIT = SYS_CLK_FREQ / BAUD_RATE` (integer division, must be ≥ 4).
- `MSG_QUEUE_SIZE`, default 32: queue depth in bytes. Must be a power of two, ≥ 2.
- `clk`  in  1  system clock. All logic is on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `rx`  in  1  asynchronous serial input. Idle high.
- `rd`  in  1  pop the queue head. Ignored while `empty`=1.
- `clr_err`  in  1  single-cycle pulse that clears `overflow` and `frame_err`.
- `msg`  out  8  queue head, first-word-fall-through. Forced to 8'h00 while `empty`=1.
- `empty`  out  1  queue holds no bytes.
- `full`  out  1  queue holds `MSG_QUEUE_SIZE` bytes.
- `overflow`  out  1  sticky: a received byte was dropped because the queue was full.
- `frame_err`  out  1  sticky: a stop bit was sampled low.

## Operation
- `rx` passes through a 2-flop synchroniser; `rx_s` is the synchronised value. Everything else uses `rx_s` only.
- Receiver FSM states are IDLE, START, DATA, STOP and BREAK. A down-counter `baud_cnt` and a 3-bit `bit_idx` drive the timing.
- IDLE: when `rx_s`=0, load `baud_cnt` with `CLKS_PER_BIT/2 - 1` and go to START.
- START: when `baud_cnt` reaches 0, sample `rx_s`.
  - If the sample is 1 (glitch), return to IDLE with no flag set.
  - If the sample is 0, reload `CLKS_PER_BIT - 1`, clear `bit_idx`, and go to DATA.
- DATA: at each counter expiry, shift `rx_s` in LSB first and reload the counter. After `bit_idx`=7 is sampled, go to STOP.
- STOP: at counter expiry, sample `rx_s`.
  - If the sample is 1, push the byte and go to IDLE. The next start edge is accepted from the following cycle.
  - If the sample is 0, discard the byte, set `frame_err`, and go to BREAK.
- BREAK: stay until `rx_s`=1, then go to IDLE. This prevents a held-low line (break) from generating spurious frames.
- Queue: circular buffer with `$clog2(MSG_QUEUE_SIZE)+1`-bit read and write pointers. `full` and `empty` are derived from the pointers, so wrap-around needs no extra state.
- Push while not full: the byte is stored.
- Push while full and `rd`=1 in the same cycle: the pop and push both occur, occupancy is unchanged, and `overflow` is not set.
- Push while full and `rd`=0: the byte is dropped and `overflow` is set.
- `rd` with `empty`=1: no effect, and the pointers do not move.
- `clr_err` clears both sticky flags. If it coincides with a new error event, the set wins.

## Timing
- Reset state, one cycle after `reset`=1 is sampled:
  - FSM in IDLE, pointers 0, shift register 0.
  - `empty`=1, `full`=0, `msg`=8'h00, `overflow`=0, `frame_err`=0.
  - Synchroniser flops set to 1 (idle).
- Reset asserted mid-frame aborts the frame; the partial byte is never pushed.
- Samples fall at `CLKS_PER_BIT/2` cycles after IDLE sees `rx_s`=0, then every `CLKS_PER_BIT` cycles.
- Line edge to IDLE detection takes 2 cycles (synchroniser).
- Push occurs in the stop-sample cycle. `empty` falls and `msg` is valid on the next cycle.
- `rd` sampled high advances the head. The new `msg`, `empty` and `full` values are visible on the next cycle.
- `frame_err` and `overflow` rise on the cycle after the stop-sample cycle.
- No handshake back-pressure exists on `rx`. Loss when full is reported only through `overflow`.

## Test plan
Use `SYS_CLK_FREQ`=16, `BAUD_RATE`=1 (`CLKS_PER_BIT`=16) and `MSG_QUEUE_SIZE`=4.
- **Single byte:** drive 0xA5 8N1 → `empty` falls 1 cycle after the stop sample and `msg`=0xA5. Pulse `rd` once → `empty`=1 and `msg`=0x00 on the next cycle.
- **Glitch rejection:** drive `rx` low for 4 cycles, then high → FSM returns to IDLE, no push, `frame_err`=0.
- **Framing error:** drive 0x3C with the stop bit low, then hold `rx` low for 40 cycles → no push, `frame_err`=1, FSM stays in BREAK. Release `rx` and send 0x42 → `msg`=0x42. Pulse `clr_err` → `frame_err`=0.
- **Overflow and wrap:** send 0x01 to 0x05 with no reads → `full`=1 after 0x04 and `overflow`=1 after 0x05. Four reads return 0x01 to 0x04, then `empty`=1. Send 0x06 and 0x07 and read them back correctly after pointer wrap.
- **Simultaneous pop and push when full:** fill with 0x10 to 0x13, then assert `rd` in the stop-sample cycle of 0x14 → `overflow`=0, `full` stays 1. The readout order is 0x11, 0x12, 0x13, 0x14.
- **Reset mid-frame:** assert `reset` for 1 cycle during data bit 3 → all outputs take their reset values. A following frame 0x81 is received correctly and is the only queued byte.
